// File: rtl/paint_pkg.sv
// Shared types and default geometry for the paint canvas framebuffer scheduler.
package paint_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BRUSH,
        CLEAR
    } state_t;

    localparam int unsigned H_RES_DEF   = 640;
    localparam int unsigned V_RES_DEF   = 480;
    localparam int unsigned COLOR_W_DEF = 12;
    localparam int unsigned FB_PIXELS   = H_RES_DEF * V_RES_DEF;

endpackage

// File: rtl/paint_brush_walker.sv
// Brush footprint iterator: walks the square stamp row-major, clips to the screen
// and produces write addresses from an incrementally stepped row base.
module paint_brush_walker
    import paint_pkg::*;
#(
    parameter int unsigned H_RES   = H_RES_DEF,
    parameter int unsigned V_RES   = V_RES_DEF,
    parameter int unsigned ADDR_W  = 19,
    parameter int unsigned BRUSH_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              advance,
    input  logic [15:0]       start_x,
    input  logic [15:0]       start_y,
    output logic              nxt_in_range,
    output logic [ADDR_W-1:0] nxt_addr,
    output logic              nxt_last
);

    localparam int unsigned R = (BRUSH_W - 1) / 2;

    logic [15:0]       cx, cy, ncx, ncy;
    logic [3:0]        dx, dy, ndx, ndy;
    logic [ADDR_W-1:0] row_base, nbase;
    logic [17:0]       px, py;

    // Outputs describe the pixel that becomes current after this edge (start or advance),
    // so the top can register them straight into the write port.
    always_comb begin
        ncx   = cx;
        ncy   = cy;
        ndx   = dx;
        ndy   = dy;
        nbase = row_base;
        if (start) begin
            ncx   = start_x;
            ncy   = start_y;
            ndx   = '0;
            ndy   = '0;
            nbase = ADDR_W'(start_y * H_RES) - ADDR_W'(R * H_RES);
        end else if (advance) begin
            if (dx == 4'(BRUSH_W - 1)) begin
                ndx   = '0;
                ndy   = dy + 4'd1;
                nbase = row_base + ADDR_W'(H_RES);
            end else begin
                ndx = dx + 4'd1;
            end
        end
        // Bit 17 doubles as the sign: inputs are 16-bit so only negatives reach it.
        px           = 18'(ncx) + 18'(ndx) - 18'(R);
        py           = 18'(ncy) + 18'(ndy) - 18'(R);
        nxt_in_range = !px[17] && (px < 18'(H_RES)) && !py[17] && (py < 18'(V_RES));
        nxt_addr     = nbase + ADDR_W'(px);
        nxt_last     = (ndx == 4'(BRUSH_W - 1)) && (ndy == 4'(BRUSH_W - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cx       <= '0;
            cy       <= '0;
            dx       <= '0;
            dy       <= '0;
            row_base <= '0;
        end else if (start || advance) begin
            cx       <= ncx;
            cy       <= ncy;
            dx       <= ndx;
            dy       <= ndy;
            row_base <= nbase;
        end
    end

endmodule

// File: rtl/paint_fb_scheduler.sv
// Framebuffer write scheduler: brush stamps from mouse events and full-screen clears.
// Optional macro PAINT_DROP_CNT_EN adds a saturating count of overwritten strokes.
module paint_fb_scheduler
    import paint_pkg::*;
#(
    parameter int unsigned H_RES   = H_RES_DEF,
    parameter int unsigned V_RES   = V_RES_DEF,
    parameter int unsigned ADDR_W  = 19,
    parameter int unsigned COLOR_W = COLOR_W_DEF,
    parameter int unsigned BRUSH_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        pos_x,
    input  logic [15:0]        pos_y,
    input  logic               mouse_left,
    input  logic               mouse_right,
    input  logic               data_valid,
    input  logic               clear_req,
    input  logic [COLOR_W-1:0] draw_color,
    input  logic [COLOR_W-1:0] bg_color,
    output logic               fb_we,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_wdata,
    input  logic               fb_ready,
    output logic               busy,
    output logic               clear_done
`ifdef PAINT_DROP_CNT_EN
    ,
    output logic [15:0]        drop_cnt
`endif
);

    localparam int unsigned FB_N = H_RES * V_RES;

    state_t             state;
    logic               stroke_pend, clear_pend, brush_last;
    logic [15:0]        lat_x, lat_y;
    logic [COLOR_W-1:0] lat_color;

    logic               cap, stroke_go, step;
    logic [15:0]        eff_x, eff_y;
    logic [COLOR_W-1:0] cap_color, eff_color;
    logic               nxt_in_range, nxt_last;
    logic [ADDR_W-1:0]  nxt_addr;

    // A capture on the same edge is used directly so an idle stroke starts one cycle later.
    assign cap       = data_valid && (mouse_left || mouse_right);
    assign cap_color = mouse_left ? draw_color : bg_color;
    assign eff_x     = cap ? pos_x : lat_x;
    assign eff_y     = cap ? pos_y : lat_y;
    assign eff_color = cap ? cap_color : lat_color;
    assign stroke_go = (state == IDLE) && !(clear_pend || clear_req) && (stroke_pend || cap);
    assign step      = (state == BRUSH) && (!fb_we || fb_ready) && !brush_last;
    assign busy      = (state != IDLE);

    paint_brush_walker #(
        .H_RES  (H_RES),
        .V_RES  (V_RES),
        .ADDR_W (ADDR_W),
        .BRUSH_W(BRUSH_W)
    ) u_walker (
        .clk         (clk),
        .rst         (rst),
        .start       (stroke_go),
        .advance     (step),
        .start_x     (eff_x),
        .start_y     (eff_y),
        .nxt_in_range(nxt_in_range),
        .nxt_addr    (nxt_addr),
        .nxt_last    (nxt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            fb_we       <= 1'b0;
            fb_addr     <= '0;
            fb_wdata    <= '0;
            clear_done  <= 1'b0;
            stroke_pend <= 1'b0;
            clear_pend  <= 1'b0;
            brush_last  <= 1'b0;
            lat_x       <= '0;
            lat_y       <= '0;
            lat_color   <= '0;
        end else begin
            clear_done  <= 1'b0;
            stroke_pend <= stroke_pend | cap;
            clear_pend  <= clear_pend | clear_req;
            if (cap) begin
                lat_x     <= pos_x;
                lat_y     <= pos_y;
                lat_color <= cap_color;
            end
            case (state)
                IDLE: begin
                    if (clear_pend || clear_req) begin
                        state      <= CLEAR;
                        clear_pend <= 1'b0;
                        fb_we      <= 1'b1;
                        fb_addr    <= '0;
                        fb_wdata   <= bg_color;
                    end else if (stroke_pend || cap) begin
                        state       <= BRUSH;
                        stroke_pend <= 1'b0;
                        fb_we       <= nxt_in_range;
                        fb_addr     <= nxt_addr;
                        fb_wdata    <= eff_color;
                        brush_last  <= nxt_last;
                    end
                end
                BRUSH: begin
                    if (!fb_we || fb_ready) begin
                        if (brush_last) begin
                            state <= IDLE;
                            fb_we <= 1'b0;
                        end else begin
                            fb_we      <= nxt_in_range;
                            fb_addr    <= nxt_addr;
                            brush_last <= nxt_last;
                        end
                    end
                end
                CLEAR: begin
                    if (fb_ready) begin
                        if (fb_addr == ADDR_W'(FB_N - 1)) begin
                            state      <= IDLE;
                            fb_we      <= 1'b0;
                            clear_done <= 1'b1;
                        end else begin
                            fb_addr <= fb_addr + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PAINT_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (cap && stroke_pend && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/paint_fb_scheduler.md
Name: paint_fb_scheduler

Overview:
Sequences framebuffer writes for the paint canvas: turns integrated mouse position plus button events into square brush stamps, and runs full-screen clear sweeps. Owns the single framebuffer write port and arbitrates between stroke and clear requests. Sits between mouse_position_integrator/ps2_mouse_receiver outputs and the framebuffer RAM write side.

Parameters:
H_RES, 640, screen width in pixels
V_RES, 480, screen height in pixels
ADDR_W, 19, framebuffer address width (must cover H_RES*V_RES-1)
COLOR_W, 12, pixel width
BRUSH_W, 3, brush side in pixels; odd, 1..15; radius R=(BRUSH_W-1)/2

Ports:
clk  in  1  system clock (single domain)
rst  in  1  synchronous, active-high reset
pos_x  in  16  cursor X, unsigned, 0..H_RES-1
pos_y  in  16  cursor Y, unsigned, 0..V_RES-1
mouse_left  in  1  draw button
mouse_right  in  1  erase button
data_valid  in  1  one-cycle pulse: new mouse sample
clear_req  in  1  one-cycle pulse: request screen clear
draw_color  in  COLOR_W  stroke color
bg_color  in  COLOR_W  erase/clear color
fb_we  out  1  write request
fb_addr  out  ADDR_W  write address = y*H_RES + x
fb_wdata  out  COLOR_W  write data
fb_ready  in  1  RAM accepts write when fb_we && fb_ready
busy  out  1  high in any state except IDLE
clear_done  out  1  one-cycle pulse after last clear write accepted

Behaviour:
- Reset (sync, rst high at posedge): state IDLE; fb_we=0, fb_addr=0, fb_wdata=0, busy=0, clear_done=0; stroke_pend=0, clear_pend=0. Reset mid-stroke/mid-clear aborts immediately, no further writes.
- Request capture (every cycle, any state): data_valid && (mouse_left||mouse_right) sets stroke_pend, latches pos_x/pos_y and color (left wins -> draw_color; right only -> bg_color). New capture while stroke_pend already set overwrites it (one-deep, newest wins). clear_req sets clear_pend. data_valid with no button: ignored.
- States: IDLE, BRUSH, CLEAR.
- IDLE: clear_pend -> CLEAR (clear has priority over stroke_pend); else stroke_pend -> BRUSH. Pending flag consumed on transition. First fb_we asserted in the cycle after the capture edge (1-cycle latency from data_valid to fb_we when idle).
- BRUSH: iterate dy=-R..+R (outer), dx=-R..+R (inner), row-major from top-left. Pixel x=cx+dx, y=cy+dy computed signed (17 bit). In-range pixel: fb_we=1, hold addr/data until fb_ready, then advance. Out-of-range pixel (x<0, x>=H_RES, y<0, y>=V_RES): one cycle with fb_we=0, advance. After last pixel: -> IDLE. Stroke is never preempted by clear.
- CLEAR: addresses 0..H_RES*V_RES-1 ascending, fb_wdata=bg_color, advance on fb_ready. After last accepted write: clear_done=1 for one cycle, -> IDLE. Strokes arriving during clear stay pending (newest wins); clear_req during CLEAR sets clear_pend again -> second sweep follows.
- Addressing: y*H_RES + x via incremental row base (add H_RES per row), no multiplier; truncated to ADDR_W.
- fb_addr/fb_wdata registered; stable whenever fb_we && !fb_ready.
- busy combinational from state.

Optional Feature:
PAINT_DROP_CNT_EN: defined -> adds output drop_cnt [15:0], counts strokes overwritten while stroke_pend=1; saturates at 0xFFFF; reset 0. Undefined -> port and counter absent, behaviour otherwise identical.

Decomposition:
- Package paint_pkg: state enum (IDLE, BRUSH, CLEAR), H_RES/V_RES defaults, COLOR_W, FB_PIXELS=H_RES*V_RES.
- Sub-module paint_brush_walker: dx/dy iterator, clipping and row-base address generation; advance/done handshake with the top FSM.

Test Plan:
- BRUSH_W=3, fb_ready=1, left held, data_valid at (100,50) -> 9 writes, first addr 31459, last 32741, all draw_color, busy drops after 9 cycles.
- data_valid at (0,0) -> 4 writes addrs 0,1,640,641 in order; 9 cycles busy; 5 clipped cycles with fb_we=0.
- fb_ready toggled 0/1 every cycle during stroke -> addr/wdata held while not ready; still exactly 9 accepted writes.
- clear_req mid-stroke -> stroke completes, then 307200 writes of bg_color addrs 0..307199, clear_done single pulse; stroke issued during clear executes afterwards.
- Three strokes during one busy stroke -> only the last serviced; drop_cnt=2 with PAINT_DROP_CNT_EN.
- rst asserted mid-clear at addr 1000 -> next cycle fb_we=0, busy=0, pend flags cleared, no clear_done.
